vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/gpu_pkg.sv | 16 +
 rtl/vram_addr_calc.sv | 17 +
 rtl/vram_arbiter.sv | 114 +++++++++++
 tb/tb_vram_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU constants: tile map geometry, VRAM sizing and CPU port FSM states.
package gpu_pkg;

  localparam int unsigned LEN_BLK_X   = 72;
  localparam int unsigned LEN_BLK_Y   = 54;
  localparam int unsigned VRAM_DEPTH  = LEN_BLK_X * LEN_BLK_Y;
  localparam int unsigned VRAM_ADDR_W = 12;
  localparam int unsigned TILE_DATA_W = 8;

  typedef enum logic [1:0] {
    CPU_IDLE = 2'd0,
    CPU_BUSY = 2'd1,
    CPU_ACK  = 2'd2
  } cpu_state_t;

endpackage

// File: rtl/vram_addr_calc.sv
// Tile map address: blk_y*72 + blk_x using shift-add (64+8).
module vram_addr_calc
  import gpu_pkg::*;
(
  input  logic [6:0]             blk_x,
  input  logic [5:0]             blk_y,
  output logic [VRAM_ADDR_W-1:0] addr
);

  logic [VRAM_ADDR_W-1:0] y_ext;
  logic [VRAM_ADDR_W-1:0] x_ext;

  assign y_ext = VRAM_ADDR_W'(blk_y);
  assign x_ext = VRAM_ADDR_W'(blk_x);
  assign addr  = (y_ext << 6) + (y_ext << 3) + x_ext;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display owns the off_x==0 slot, CPU uses the rest.
// Define VRAM_CPU_READ_EN to allow CPU reads; otherwise reads return 0 without access.
module vram_arbiter
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = TILE_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        blk_x,
  input  logic [5:0]        blk_y,
  input  logic [2:0]        off_x,
  input  logic              in_mem,
  output logic [DATA_W-1:0] tile_code,
  output logic              tile_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef VRAM_CPU_READ_EN
  localparam logic READ_EN = 1'b1;
`else
  localparam logic READ_EN = 1'b0;
`endif

  cpu_state_t             state, state_nxt;
  logic                   disp_slot, disp_pend;
  logic                   in_range, cpu_live;
  logic                   rd_q, rd_nxt, zero_q, zero_nxt;
  logic [VRAM_ADDR_W-1:0] disp_addr;

  vram_addr_calc u_addr_calc (
    .blk_x (blk_x),
    .blk_y (blk_y),
    .addr  (disp_addr)
  );

  assign disp_slot = (off_x == 3'd0) && in_mem;
  assign in_range  = 32'(cpu_addr) < VRAM_DEPTH;
  assign cpu_live  = in_range && (cpu_we || READ_EN);
  assign cpu_ack   = (state == CPU_ACK);

  // Any accepted request that does not touch memory (out of range or a
  // disabled read) zeroes cpu_rdata; in-range writes leave it alone.
  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    rd_nxt    = rd_q;
    zero_nxt  = zero_q;
    if (disp_slot) mem_addr = ADDR_W'(disp_addr);
    case (state)
      CPU_IDLE: begin
        if (cpu_req && !disp_slot) begin
          state_nxt = CPU_BUSY;
          rd_nxt    = cpu_live && !cpu_we;
          zero_nxt  = !cpu_live;
          if (cpu_live) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
          end
        end
      end
      CPU_BUSY: state_nxt = CPU_ACK;
      CPU_ACK:  state_nxt = CPU_IDLE;
      default:  state_nxt = CPU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CPU_IDLE;
      rd_q      <= 1'b0;
      zero_q    <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      state  <= state_nxt;
      rd_q   <= rd_nxt;
      zero_q <= zero_nxt;
      if (state == CPU_BUSY) begin
        if (rd_q)        cpu_rdata <= mem_rdata;
        else if (zero_q) cpu_rdata <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_pend  <= 1'b0;
      tile_code  <= '0;
      tile_valid <= 1'b0;
    end else begin
      disp_pend <= disp_slot;
      if (disp_pend) begin
        tile_code  <= mem_rdata;
        tile_valid <= 1'b1;
      end else if ((off_x == 3'd0) && !in_mem) begin
        tile_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural 1-cycle-latency VRAM.
module tb_vram_arbiter;
  import gpu_pkg::*;

`ifdef VRAM_CPU_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  typedef struct {
    int unsigned ack_cyc;
    logic [7:0]  rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  blk_x = '0;
  logic [5:0]  blk_y = '0;
  logic [2:0]  off_x = '0;
  logic        in_mem = 1'b0;
  logic [7:0]  tile_code;
  logic        tile_valid;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;

  logic [7:0]  ram    [0:4095];
  logic [7:0]  shadow [0:4095];
  logic [7:0]  model_rdata = '0;
  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned we_count = 0;
  int unsigned ack_count = 0;
  bit          ack_seen = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  vram_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .blk_x      (blk_x),
    .blk_y      (blk_y),
    .off_x      (off_x),
    .in_mem     (in_mem),
    .tile_code  (tile_code),
    .tile_valid (tile_valid),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Free-running pixel offset, updated just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1 off_x = off_x + 3'd1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) we_count++;
      if (cpu_ack) begin
        exp_t e;
        ack_seen = 1'b1;
        ack_count++;
        if (sb.size() == 0) begin
          check("ack_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ack_cycle", cyc, e.ack_cyc);
          check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e.rdata});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_off(input logic [2:0] v);
    for (int i = 0; i < 16 && off_x != v; i++) next_cyc();
    check("wait_off", {29'd0, off_x}, {29'd0, v});
  endtask

  task automatic cpu_access(input logic we, input logic [11:0] addr,
                            input logic [7:0] wd, input logic keep_req);
    exp_t        e;
    logic        live;
    int unsigned issue_c;
    logic [11:0] dexp;
    bit          got;
    live    = (addr < 12'd3888) && (we || READ_EN);
    issue_c = (off_x == 3'd0 && in_mem) ? cyc + 1 : cyc;
    if (live && we)       shadow[addr] = wd;
    if (live && !we)      model_rdata = shadow[addr];
    else if (!live)       model_rdata = '0;
    e.ack_cyc = issue_c + 2;
    e.rdata   = model_rdata;
    sb.push_back(e);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    ack_seen  = 1'b0;
    @(negedge clk);
    if (issue_c != cyc) begin
      dexp = 12'(blk_y) * 12'd72 + 12'(blk_x);
      check("stall_addr", {20'd0, mem_addr}, {20'd0, dexp});
      check("stall_we", {31'd0, mem_we}, 32'd0);
      @(negedge clk);
    end
    if (live) begin
      check("issue_addr", {20'd0, mem_addr}, {20'd0, addr});
      check("issue_we", {31'd0, mem_we}, {31'd0, we});
      if (we) check("issue_wdata", {24'd0, mem_wdata}, {24'd0, wd});
    end else begin
      check("noissue_we", {31'd0, mem_we}, 32'd0);
      check("noissue_addr", {31'd0, (mem_addr == addr)}, 32'd0);
    end
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      next_cyc();
      if (ack_seen) begin
        got = 1'b1;
        break;
      end
    end
    check("ack_seen", {31'd0, got}, 32'd1);
    if (!keep_req) cpu_req = 1'b0;
  endtask

  initial begin
    int unsigned we_before;
    int unsigned ack_before;
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 37 + 11);
    ram[149]  = 8'hA5;
    ram[32]   = 8'h5E;
    ram[3887] = 8'h3D;
    for (int i = 0; i < 4096; i++) shadow[i] = ram[i];

    repeat (3) @(posedge clk);
    #2;
    check("rst_ack", {31'd0, cpu_ack}, 32'd0);
    check("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
    check("rst_tile_code", {24'd0, tile_code}, 32'd0);
    check("rst_tile_valid", {31'd0, tile_valid}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    rst_n = 1'b1;

    // Display fetch of tile (5,2) -> address 149
    blk_x = 7'd5; blk_y = 6'd2; in_mem = 1'b1;
    wait_off(3'd0);
    @(negedge clk);
    check("disp_addr", {20'd0, mem_addr}, 32'd149);
    check("disp_we", {31'd0, mem_we}, 32'd0);
    next_cyc(); next_cyc();
    @(negedge clk);
    check("tile_code", {24'd0, tile_code}, {24'd0, shadow[149]});
    check("tile_valid", {31'd0, tile_valid}, 32'd1);

    // Last tile of the map -> address 3887
    blk_x = 7'd71; blk_y = 6'd53;
    wait_off(3'd0);
    @(negedge clk);
    check("disp_addr_max", {20'd0, mem_addr}, 32'd3887);
    next_cyc(); next_cyc();
    @(negedge clk);
    check("tile_code_max", {24'd0, tile_code}, {24'd0, shadow[3887]});

    // Leaving the active area clears valid but keeps the code
    in_mem = 1'b0;
    wait_off(3'd0);
    next_cyc();
    @(negedge clk);
    check("valid_clear", {31'd0, tile_valid}, 32'd0);
    check("code_hold", {24'd0, tile_code}, {24'd0, shadow[3887]});
    next_cyc();

    // CPU write in a CPU slot
    blk_x = 7'd5; blk_y = 6'd2; in_mem = 1'b1;
    wait_off(3'd3);
    cpu_access(1'b1, 12'h010, 8'h3C, 1'b0);
    check("ram_010", {24'd0, ram[16]}, 32'h3C);

    // CPU read raised in a display slot stalls one cycle
    wait_off(3'd0);
    cpu_access(1'b0, 12'h020, 8'h00, 1'b0);
    cpu_access(1'b0, 12'h010, 8'h00, 1'b0);

    // Back-to-back writes in blanking with cpu_req held high
    in_mem = 1'b0;
    next_cyc();
    we_before = we_count;
    for (int k = 0; k < 8; k++)
      cpu_access(1'b1, 12'(12'h100 + k), 8'(8'hC0 + k), k != 7);
    check("b2b_we_count", we_count - we_before, 32'd8);
    for (int k = 0; k < 8; k++)
      check("b2b_ram", {24'd0, ram[12'h100 + k]}, {24'd0, shadow[12'h100 + k]});

    // Out-of-range accesses
    we_before = we_count;
    cpu_access(1'b1, 12'd4000, 8'h77, 1'b0);
    cpu_access(1'b0, 12'd4000, 8'h00, 1'b0);
    check("oor_no_we", we_count - we_before, 32'd0);
    cpu_access(1'b0, 12'd3887, 8'h00, 1'b0);

    // Reset during BUSY abandons the access
    next_cyc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h040; cpu_wdata = 8'h99;
    shadow[12'h040] = 8'h99;
    next_cyc();
    rst_n = 1'b0;
    cpu_req = 1'b0;
    ack_before = ack_count;
    @(negedge clk);
    check("rst2_ack", {31'd0, cpu_ack}, 32'd0);
    check("rst2_rdata", {24'd0, cpu_rdata}, 32'd0);
    check("rst2_tile_code", {24'd0, tile_code}, 32'd0);
    check("rst2_tile_valid", {31'd0, tile_valid}, 32'd0);
    check("rst2_mem_we", {31'd0, mem_we}, 32'd0);
    next_cyc();
    rst_n = 1'b1;
    model_rdata = '0;
    repeat (4) next_cyc();
    check("rst2_no_ack", ack_count - ack_before, 32'd0);

    cpu_access(1'b0, 12'h020, 8'h00, 1'b0);
    next_cyc();
    check("sb_drain", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
